axi_sram_slave: RTL and testbench



---
 rtl/axi_sram_slave.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 responder backed by a single-port, word-addressed SRAM.
// Only one transaction is in service at a time. When AW and AR are both
// valid in IDLE, the grant alternates between write and read, starting
// with write.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_aw*               write address channel (id, addr, len, size, burst)
//   s_w*                write data channel (data, strobes, last)
//   s_b*                write response channel
//   s_ar*               read address channel
//   s_r*                read data channel
//
// Optional feature: define AXI_SRAM_WRAP_BURST_EN to support WRAP bursts.
// Without it, a WRAP burst is answered with SLVERR on every beat. Write
// beats of such a burst are discarded, and read beats return zero.
module axi_sram_slave #(
    parameter int          ID_WIDTH    = 6,
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [ID_WIDTH-1:0] s_awid,
    input  logic [31:0]         s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [31:0]         s_wdata,
    input  logic [3:0]          s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [ID_WIDTH-1:0] s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ID_WIDTH-1:0] s_arid,
    input  logic [31:0]         s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [ID_WIDTH-1:0] s_rid,
    output logic [31:0]         s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
`ifdef AXI_SRAM_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
    state_t state_reg, state_next;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic [ID_WIDTH-1:0] id_reg;
    logic [31:0]         addr_reg, addr_next, incr;
    logic [7:0]          len_reg, beat_reg;
    logic [2:0]          size_reg;
    logic [1:0]          burst_reg;
    logic                burst_err_reg, err_reg, last_was_write_reg, issue_done_reg;

    // Read pipeline: SRAM output stage, then the output register, then the skid buffer.
    logic        rd_valid_reg, rd_err_reg, rd_last_reg;
    logic [31:0] ram_q_reg, rd_word;
    logic        out_valid_reg, out_err_reg, out_last_reg;
    logic [31:0] out_data_reg;
    logic        skid_valid_reg, skid_err_reg, skid_last_reg;
    logic [31:0] skid_data_reg;

    logic            sel_write, sel_read, acc_err, beat_err, last_beat, in_range;
    logic [7:0]      acc_len;
    logic [2:0]      acc_size;
    logic [1:0]      acc_burst;
    logic            w_hs, pop, load_out, rd_issue, r_done, mem_we;
    logic [1:0]      occ;
    logic [3:0]      lane_we;
    logic [AW-1:0]   word_idx;

    assign sel_write = s_awvalid && (!s_arvalid || !last_was_write_reg);
    assign sel_read  = s_arvalid && !sel_write;
    assign acc_len   = sel_write ? s_awlen   : s_arlen;
    assign acc_size  = sel_write ? s_awsize  : s_arsize;
    assign acc_burst = sel_write ? s_awburst : s_arburst;

    always_comb begin
        acc_err = (acc_size > 3'd2) || (acc_burst == 2'b11);
        if (acc_burst == 2'b10) begin
            if (!WRAP_EN)
                acc_err = 1'b1;
            else if (!(acc_len == 8'd1 || acc_len == 8'd3 || acc_len == 8'd7 || acc_len == 8'd15))
                acc_err = 1'b1;
        end
    end

    // Offset is compared in 33 bits so a window ending at 4 GiB still works.
    assign in_range  = (addr_reg >= BASE_ADDR) && ({1'b0, addr_reg - BASE_ADDR} < SPAN);
    assign word_idx  = AW'((addr_reg - BASE_ADDR) >> 2);
    assign beat_err  = burst_err_reg || !in_range;
    assign last_beat = (beat_reg == len_reg);

`ifdef AXI_SRAM_WRAP_BURST_EN
    logic [31:0] wrap_mask;
    assign wrap_mask = ((32'(len_reg) + 32'd1) << size_reg) - 32'd1;
`endif
    always_comb begin
        incr = 32'd1 << size_reg;
        case (burst_reg)
            2'b00:   addr_next = addr_reg;
`ifdef AXI_SRAM_WRAP_BURST_EN
            2'b10:   addr_next = (addr_reg & ~wrap_mask) | ((addr_reg + incr) & wrap_mask);
`endif
            default: addr_next = addr_reg + incr;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        s_awready  = 1'b0;
        s_arready  = 1'b0;
        s_wready   = 1'b0;
        s_bvalid   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_write) begin
                    s_awready  = 1'b1;
                    state_next = WDATA;
                end else if (sel_read) begin
                    s_arready  = 1'b1;
                    state_next = RDATA;
                end
            end
            WDATA: begin
                s_wready = 1'b1;
                if (s_wvalid && last_beat) state_next = WRESP;
            end
            WRESP: begin
                s_bvalid = 1'b1;
                if (s_bready) state_next = IDLE;
            end
            RDATA:   if (r_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign w_hs     = s_wready && s_wvalid;
    assign mem_we   = w_hs && !beat_err;
    assign pop      = out_valid_reg && s_rready;
    assign load_out = !out_valid_reg || pop;
    assign r_done   = pop && out_last_reg;
    assign occ      = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, rd_valid_reg};
    // Only issue a read if its data will have a free slot when it returns.
    assign rd_issue = (state_reg == RDATA) && !issue_done_reg &&
                      ((occ < 2'd2) || ((occ == 2'd2) && pop));
    assign rd_word  = rd_err_reg ? 32'd0 : ram_q_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = mem_we && s_wstrb[gi];
        end
    endgenerate

    always_ff @(posedge aclk) begin
        for (int b = 0; b < 4; b++)
            if (lane_we[b]) mem[word_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
        if (rd_issue) ram_q_reg <= mem[word_idx];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg          <= IDLE;
            id_reg             <= '0;
            addr_reg           <= '0;
            len_reg            <= '0;
            size_reg           <= '0;
            burst_reg          <= '0;
            beat_reg           <= '0;
            burst_err_reg      <= 1'b0;
            err_reg            <= 1'b0;
            last_was_write_reg <= 1'b0;
            issue_done_reg     <= 1'b0;
            rd_valid_reg       <= 1'b0;
            rd_err_reg         <= 1'b0;
            rd_last_reg        <= 1'b0;
            out_valid_reg      <= 1'b0;
            out_data_reg       <= '0;
            out_err_reg        <= 1'b0;
            out_last_reg       <= 1'b0;
            skid_valid_reg     <= 1'b0;
            skid_data_reg      <= '0;
            skid_err_reg       <= 1'b0;
            skid_last_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (s_awready || s_arready) begin
                id_reg         <= sel_write ? s_awid : s_arid;
                addr_reg       <= sel_write ? s_awaddr : s_araddr;
                len_reg        <= acc_len;
                size_reg       <= acc_size;
                burst_reg      <= acc_burst;
                burst_err_reg  <= acc_err;
                beat_reg       <= '0;
                err_reg        <= 1'b0;
                issue_done_reg <= 1'b0;
            end
            if (w_hs) begin
                addr_reg <= addr_next;
                err_reg  <= err_reg || beat_err || (s_wlast != last_beat);
                if (!last_beat) beat_reg <= beat_reg + 8'd1;
            end
            if (rd_issue) begin
                addr_reg    <= addr_next;
                rd_err_reg  <= beat_err;
                rd_last_reg <= last_beat;
                if (last_beat) issue_done_reg <= 1'b1;
                else           beat_reg       <= beat_reg + 8'd1;
            end
            rd_valid_reg <= rd_issue;

            if (load_out) begin
                if (skid_valid_reg) begin
                    out_valid_reg  <= 1'b1;
                    out_data_reg   <= skid_data_reg;
                    out_err_reg    <= skid_err_reg;
                    out_last_reg   <= skid_last_reg;
                    skid_valid_reg <= rd_valid_reg;
                    skid_data_reg  <= rd_word;
                    skid_err_reg   <= rd_err_reg;
                    skid_last_reg  <= rd_last_reg;
                end else if (rd_valid_reg) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= rd_word;
                    out_err_reg   <= rd_err_reg;
                    out_last_reg  <= rd_last_reg;
                end else begin
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            end else if (rd_valid_reg) begin
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= rd_word;
                skid_err_reg   <= rd_err_reg;
                skid_last_reg  <= rd_last_reg;
            end

            if (s_bvalid && s_bready) last_was_write_reg <= 1'b1;
            if (r_done)               last_was_write_reg <= 1'b0;
        end
    end

    assign s_bid   = id_reg;
    assign s_bresp = (s_bvalid && err_reg) ? 2'b10 : 2'b00;
    assign s_rid   = id_reg;
    assign s_rvalid = out_valid_reg;
    assign s_rdata = out_data_reg;
    assign s_rresp = {out_err_reg, 1'b0};
    assign s_rlast = out_last_reg;

endmodule

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
module tb_axi_sram_slave;
    localparam int          IDW   = 6;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic            aclk = 1'b0;
    logic            areset;
    logic [IDW-1:0]  s_awid, s_arid, s_bid, s_rid;
    logic [31:0]     s_awaddr, s_araddr, s_wdata, s_rdata;
    logic [7:0]      s_awlen, s_arlen;
    logic [2:0]      s_awsize, s_arsize;
    logic [1:0]      s_awburst, s_arburst, s_bresp, s_rresp;
    logic [3:0]      s_wstrb;
    logic            s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic            s_bvalid, s_bready, s_arvalid, s_arready;
    logic            s_rlast, s_rvalid, s_rready;

    axi_sram_slave #(.ID_WIDTH(IDW), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .aclk(aclk), .areset(areset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    data;
        logic [1:0]     resp;
        logic           last;
    } rbeat_t;
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } bexp_t;

    rbeat_t      r_q[$];
    bexp_t       b_q[$];
    logic [31:0] model [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    int          vectors = 0;
    int          miscompares = 0;
    int          lat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic burst_bad(logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        logic b;
        b = (size > 3'd2) || (burst == 2'b11);
        if (burst == 2'b10) begin
`ifdef AXI_SRAM_WRAP_BURST_EN
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) b = 1'b1;
`else
            b = 1'b1;
`endif
        end
        return b;
    endfunction

    function automatic logic [31:0] beat_addr(logic [31:0] start, logic [7:0] len,
                                              logic [2:0] size, logic [1:0] burst, int i);
        longint unsigned step, wb, s;
        step = 64'd1 << size;
        s    = longint'(start);
        case (burst)
            2'b00: return start;
            2'b10: begin
                wb = (longint'(len) + 1) * step;
                return 32'((s / wb) * wb + ((s % wb) + longint'(i) * step) % wb);
            end
            default: return 32'(s + longint'(i) * step);
        endcase
    endfunction

    function automatic logic in_rng(logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) - longint'(BASE) < longint'(4 * DEPTH));
    endfunction

    task automatic push_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic bad, err;
        logic [31:0] a;
        int idx;
        bad = burst_bad(len, size, burst);
        err = bad;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, size, burst, i);
            if (bad || !in_rng(a)) err = 1'b1;
            else begin
                idx = int'((a - BASE) >> 2);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[idx][b*8 +: 8] = wd[i][b*8 +: 8];
            end
        end
        b_q.push_back({id, err ? 2'b10 : 2'b00});
    endtask

    task automatic push_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        logic bad, e;
        logic [31:0] a;
        bad = burst_bad(len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, len, size, burst, i);
            e = bad || !in_rng(a);
            r_q.push_back({id, e ? 32'd0 : model[int'((a - BASE) >> 2)], e ? 2'b10 : 2'b00, i == int'(len)});
        end
    endtask

    task automatic set_aw(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst; s_awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_arvalid = 1'b1;
    endtask

    task automatic aw_handshake();
        int n = 0;
        #1;
        while (!s_awready && n < 100) begin @(posedge aclk); #1; n++; end
        check("aw_ready", s_awready, 1'b1);
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
    endtask

    task automatic ar_handshake();
        int n = 0;
        #1;
        while (!s_arready && n < 100) begin @(posedge aclk); #1; n++; end
        check("ar_ready", s_arready, 1'b1);
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic w_beats(input int len);
        int n;
        for (int i = 0; i <= len; i++) begin
            s_wvalid = 1'b1; s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i == len);
            n = 0;
            #1;
            while (!s_wready && n < 100) begin @(posedge aclk); #1; n++; end
            if (!s_wready) check("w_ready", s_wready, 1'b1);
            @(posedge aclk); #1;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
    endtask

    task automatic b_wait();
        int n = 0;
        bexp_t e;
        s_bready = 1'b1;
        #1;
        while (!s_bvalid && n < 100) begin @(posedge aclk); #1; n++; end
        e = (b_q.size() > 0) ? b_q.pop_front() : '0;
        check("b_resp", {s_bvalid, s_bid, s_bresp}, {1'b1, e});
        $display("B   id=%0d resp=%b", s_bid, s_bresp);
        @(posedge aclk); #1;
        s_bready = 1'b0;
    endtask

    task automatic r_collect(input int n, input bit toggle, output int first_lat);
        int got = 0, cyc = 0;
        logic held_v = 1'b0;
        rbeat_t held, cur, e;
        first_lat = -1;
        while (got < n && cyc < 3000) begin
            s_rready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            cur = {s_rid, s_rdata, s_rresp, s_rlast};
            if (held_v) begin
                check("r_stable", {s_rvalid, cur}, {1'b1, held});
                held_v = 1'b0;
            end
            if (s_rvalid) begin
                if (first_lat < 0) first_lat = cyc;
                if (s_rready) begin
                    e = (r_q.size() > 0) ? r_q.pop_front() : '0;
                    check("r_beat", cur, e);
                    $display("R   id=%0d data=%h resp=%b last=%b", s_rid, s_rdata, s_rresp, s_rlast);
                    got++;
                end else begin
                    held   = cur;
                    held_v = 1'b1;
                end
            end
            @(posedge aclk); #1;
            cyc++;
        end
        s_rready = 1'b0;
        check("r_count", got, n);
        check("r_extra", s_rvalid, 1'b0);
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        push_write(id, addr, len, size, burst);
        set_aw(id, addr, len, size, burst);
        aw_handshake();
        w_beats(int'(len));
        b_wait();
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                           output int first_lat);
        push_read(id, addr, len, size, burst);
        set_ar(id, addr, len, size, burst);
        ar_handshake();
        r_collect(int'(len) + 1, toggle, first_lat);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        areset = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_ctrl", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast}, 6'd0);
        check("rst_data", {s_bresp, s_rresp, s_bid, s_rid, s_rdata}, '0);
        areset = 1'b0;
        @(posedge aclk); #1;

        // INCR write then read back, with first-beat latency check
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(6'd5, 32'h10, 8'd3, 3'd2, 2'b01);
        do_read(6'd9, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0, lat);
        check("r_first_latency", lat, 2);

        // byte strobes
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(6'd1, 32'h80, 8'd0, 3'd2, 2'b01);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(6'd2, 32'h80, 8'd0, 3'd2, 2'b01);
        do_read(6'd3, 32'h80, 8'd0, 3'd2, 2'b01, 1'b0, lat);

        // simultaneous AW/AR twice: write wins, then read wins
        wd[0] = 32'hCAFE0001; ws[0] = 4'hF;
        push_write(6'd3, 32'h40, 8'd0, 3'd2, 2'b01);
        set_aw(6'd3, 32'h40, 8'd0, 3'd2, 2'b01);
        set_ar(6'd4, 32'h10, 8'd0, 3'd2, 2'b01);
        #1;
        check("grant_first", {s_awready, s_arready}, 2'b10);
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        check("ar_blocked_in_write", s_arready, 1'b0);
        w_beats(0);
        wd[0] = 32'hCAFE0002;
        push_write(6'd5, 32'h44, 8'd0, 3'd2, 2'b01);
        set_aw(6'd5, 32'h44, 8'd0, 3'd2, 2'b01);
        b_wait();
        #1;
        check("grant_second", {s_awready, s_arready}, 2'b01);
        push_read(6'd4, 32'h10, 8'd0, 3'd2, 2'b01);
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
        check("aw_blocked_in_read", s_awready, 1'b0);
        r_collect(1, 1'b0, lat);
        aw_handshake();
        w_beats(0);
        b_wait();
        do_read(6'd6, 32'h40, 8'd1, 3'd2, 2'b01, 1'b0, lat);

        // len=7 read with rready toggling
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(6'd7, 32'h100, 8'd7, 3'd2, 2'b01);
        do_read(6'd8, 32'h100, 8'd7, 3'd2, 2'b01, 1'b1, lat);

        // top-of-memory boundary: second beat out of range
        wd[0] = 32'hDEAD0001; wd[1] = 32'hDEAD0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(6'd10, BASE + 32'(4 * DEPTH) - 32'd4, 8'd1, 3'd2, 2'b01);
        do_read(6'd11, BASE + 32'(4 * DEPTH) - 32'd4, 8'd1, 3'd2, 2'b01, 1'b0, lat);

        // WRAP read and write (outcome depends on the build option)
        do_read(6'd12, 32'h18, 8'd3, 3'd2, 2'b10, 1'b0, lat);
        wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2; wd[3] = 32'hB3;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(6'd13, 32'h18, 8'd3, 3'd2, 2'b10);
        do_read(6'd14, 32'h10, 8'd3, 3'd2, 2'b01, 1'b0, lat);

        // unsupported size and FIXED bursts
        do_read(6'd15, 32'h10, 8'd1, 3'd3, 2'b01, 1'b0, lat);
        wd[0] = 32'hF0; wd[1] = 32'hF1; wd[2] = 32'hF2;
        for (int i = 0; i < 3; i++) ws[i] = 4'hF;
        do_write(6'd16, 32'h200, 8'd2, 3'd2, 2'b00);
        do_read(6'd17, 32'h200, 8'd2, 3'd2, 2'b00, 1'b1, lat);

        // longest INCR burst
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(6'd18, 32'h400, 8'd255, 3'd2, 2'b01);
        do_read(6'd19, 32'h400, 8'd255, 3'd2, 2'b01, 1'b0, lat);

        // reset in the middle of a read burst
        set_ar(6'd20, 32'h100, 8'd15, 3'd2, 2'b01);
        ar_handshake();
        s_rready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rvalid_before_reset", s_rvalid, 1'b1);
        areset = 1'b1;
        @(posedge aclk); #1;
        check("r_after_reset", {s_rvalid, s_rlast, s_rdata}, '0);
        areset = 1'b0;
        s_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk); #1;
            check("no_r_after_reset", s_rvalid, 1'b0);
        end
        s_rready = 1'b0;
        wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
        push_write(6'd21, 32'h300, 8'd0, 3'd2, 2'b01);
        set_aw(6'd21, 32'h300, 8'd0, 3'd2, 2'b01);
        #1;
        check("idle_after_reset", s_awready, 1'b1);
        aw_handshake();
        w_beats(0);
        b_wait();
        do_read(6'd22, 32'h300, 8'd0, 3'd2, 2'b01, 1'b0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
